// File: rtl/serial_deframer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : serial_deframer_pkg
// Purpose : Shared definitions for the serial framer/deframer pair: FSM state
//           encoding (2 bits) and frame line-level constants.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package serial_deframer_pkg;

  // Receiver FSM states, explicit 2-bit encoding shared with the serializer.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_t;

  // Frame line levels.
  localparam logic START_BIT = 1'b1;
  localparam logic STOP_BIT  = 1'b0;
  localparam logic IDLE_LVL  = 1'b0;

endpackage : serial_deframer_pkg
`default_nettype wire

// File: rtl/serial_deframer_if.sv
`default_nettype none
// ============================================================================
// Module  : serial_deframer_if
// Purpose : Output word handshake bundle of the deframer.
// Ports   : o_data  - received word
//           o_valid - word/flags valid
//           o_perr  - parity mismatch on o_data
//           o_ferr  - framing (stop bit) error on o_data
//           i_ready - consumer accepts when o_valid & i_ready
// Rev     : 1.0  initial release
// ============================================================================
interface serial_deframer_if #(
  parameter int NBIT = 8
);
  logic [NBIT-1:0] o_data;
  logic            o_valid;
  logic            o_perr;
  logic            o_ferr;
  logic            i_ready;

  modport master (output o_data, output o_valid, output o_perr, output o_ferr,
                  input  i_ready);
  modport slave  (input  o_data, input  o_valid, input  o_perr, input  o_ferr,
                  output i_ready);
endinterface : serial_deframer_if
`default_nettype wire

// File: rtl/serial_deframer_obuf.sv
`default_nettype none
// ============================================================================
// Module  : serial_deframer_obuf
// Purpose : One-entry valid/ready holding register for completed words, with
//           a sticky overflow flag for words that arrive while full.
// Ports   : i_clk, i_rst         - clock, async active-high reset
//           i_load               - a word completed this cycle
//           i_data/i_perr/i_ferr - completed word and its error flags
//           i_ready              - consumer accepts
//           i_clr                - clears sticky overflow
//           o_data/o_valid/o_perr/o_ferr - held word
//           o_ovf                - sticky drop indicator
// Rev     : 1.0  initial release
// ============================================================================
module serial_deframer_obuf #(
  parameter int NBIT = 8
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_load,
  input  logic [NBIT-1:0] i_data,
  input  logic            i_perr,
  input  logic            i_ferr,
  input  logic            i_ready,
  input  logic            i_clr,
  output logic [NBIT-1:0] o_data,
  output logic            o_valid,
  output logic            o_perr,
  output logic            o_ferr,
  output logic            o_ovf
);

  logic [NBIT-1:0] data_q;
  logic            valid_q, perr_q, ferr_q, ovf_q;
  logic            take_w, drop_w;

  // A new word is taken when the slot is empty or being drained this cycle;
  // otherwise it is lost and the overflow flag records it.
  assign take_w = i_load & (~valid_q | i_ready);
  assign drop_w = i_load & valid_q & ~i_ready;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      if (take_w) begin
        data_q  <= i_data;
        perr_q  <= i_perr;
        ferr_q  <= i_ferr;
        valid_q <= 1'b1;
      end else if (valid_q & i_ready) begin
        valid_q <= 1'b0;
      end
      // Set has priority over clear.
      if (drop_w) begin
        ovf_q <= 1'b1;
      end else if (i_clr) begin
        ovf_q <= 1'b0;
      end
    end
  end

  assign o_data  = data_q;
  assign o_valid = valid_q;
  assign o_perr  = perr_q;
  assign o_ferr  = ferr_q;
  assign o_ovf   = ovf_q;

endmodule : serial_deframer_obuf
`default_nettype wire

// File: rtl/serial_deframer.sv
`default_nettype none
// ============================================================================
// Module  : serial_deframer
// Purpose : Recovers start/data(MSB first)/even-parity/stop frames from a
//           serial bit stream, flags parity and stop-bit errors, and hands
//           words to a one-entry valid/ready output buffer.
// Ports   : i_clk, i_rst - clock, async active-high reset
//           i_s          - serial input bit
//           i_bit_en     - bit strobe; state only advances when 1
//           i_clr        - clears sticky overflow
//           o_ovf        - sticky: a completed word was dropped
//           o_busy       - receiver not idle
//           out_if       - word handshake (data/valid/perr/ferr/ready)
// Rev     : 1.0  initial release
// ============================================================================
module serial_deframer #(
  parameter int NBIT      = 8,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_s,
  input  logic               i_bit_en,
  input  logic               i_clr,
  output logic               o_ovf,
  output logic               o_busy,
  serial_deframer_if.master  out_if
);
  import serial_deframer_pkg::*;

  localparam int CW = $clog2(NBIT + 1);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NBIT-1:0] shift_q, shift_d;
  logic            perr_q, perr_d;
  logic            load_w, ferr_w;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      perr_q  <= perr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    perr_d  = perr_q;
    load_w  = 1'b0;
    ferr_w  = 1'b0;
    if (i_bit_en) begin
      case (state_q)
        ST_IDLE: begin
          if (i_s == START_BIT) begin
            state_d = ST_DATA;
            cnt_d   = '0;
            perr_d  = 1'b0;
          end
        end
        ST_DATA: begin
          shift_d = (shift_q << 1) | NBIT'(i_s);
          cnt_d   = cnt_q + CW'(1);
          if (cnt_q == CW'(NBIT - 1)) begin
            state_d = PARITY_EN ? ST_PARITY : ST_STOP;
          end
        end
        ST_PARITY: begin
          // Even parity: received bit plus data ones must be even.
          perr_d  = i_s ^ (^shift_q);
          state_d = ST_STOP;
        end
        ST_STOP: begin
          ferr_w  = (i_s != STOP_BIT);
          load_w  = 1'b1;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign o_busy = (state_q != ST_IDLE);

  serial_deframer_obuf #(
    .NBIT (NBIT)
  ) u_obuf (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_load  (load_w),
    .i_data  (shift_q),
    .i_perr  (perr_q),
    .i_ferr  (ferr_w),
    .i_ready (out_if.i_ready),
    .i_clr   (i_clr),
    .o_data  (out_if.o_data),
    .o_valid (out_if.o_valid),
    .o_perr  (out_if.o_perr),
    .o_ferr  (out_if.o_ferr),
    .o_ovf   (o_ovf)
  );

endmodule : serial_deframer
`default_nettype wire

// File: tb/tb_serial_deframer.sv
`default_nettype none
// ============================================================================
// Module  : tb_serial_deframer
// Purpose : Self-checking bench for serial_deframer: directed frame table,
//           hand-written handshake/reset sequences and randomized frames,
//           all compared against a frame-level reference model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_serial_deframer;

  localparam int NBIT = 8;
  localparam int FLEN = NBIT + 2;   // data + parity + stop after the start bit

  logic i_clk = 1'b0;
  logic i_rst, i_s, i_bit_en, i_clr;
  logic o_ovf, o_busy;

  serial_deframer_if #(.NBIT(NBIT)) bus ();

  serial_deframer #(.NBIT(NBIT), .PARITY_EN(1'b1)) dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_s      (i_s),
    .i_bit_en (i_bit_en),
    .i_clr    (i_clr),
    .o_ovf    (o_ovf),
    .o_busy   (o_busy),
    .out_if   (bus)
  );

  always #5 i_clk = ~i_clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (frame level) ----------------
  bit            m_inframe;
  bit            m_bits[$];
  bit            m_valid, m_perr, m_ferr, m_ovf;
  logic [NBIT-1:0] m_data;

  task automatic model_reset();
    m_inframe = 0;
    m_bits.delete();
    m_valid = 0; m_perr = 0; m_ferr = 0; m_ovf = 0; m_data = '0;
  endtask

  task automatic model_edge(input bit s, input bit en, input bit rdy, input bit clr);
    bit complete = 0;
    bit drop;
    logic [NBIT-1:0] w = '0;
    bit wp = 0, wf = 0;
    if (en) begin
      if (!m_inframe) begin
        if (s) begin m_inframe = 1; m_bits.delete(); end
      end else begin
        m_bits.push_back(s);
        if (m_bits.size() == FLEN) begin
          for (int i = 0; i < NBIT; i++) w = (w << 1) | NBIT'(m_bits[i]);
          wp = ((int'(m_bits[NBIT]) + $countones(w)) % 2) != 0;
          wf = m_bits[NBIT+1];
          complete  = 1;
          m_inframe = 0;
        end
      end
    end
    drop = complete && m_valid && !rdy;
    if (complete && !drop) begin
      m_valid = 1; m_data = w; m_perr = wp; m_ferr = wf;
    end else if (!complete && m_valid && rdy) begin
      m_valid = 0;
    end
    if (drop) m_ovf = 1;
    else if (clr) m_ovf = 0;
  endtask

  // One clock: drive inputs, let the edge happen, then compare with the model.
  task automatic step(input bit s, input bit en, input bit rdy, input bit clr);
    i_s = s; i_bit_en = en; bus.i_ready = rdy; i_clr = clr;
    @(posedge i_clk);
    model_edge(s, en, rdy, clr);
    #1;
    chk("model.valid", bus.o_valid, m_valid);
    chk("model.data",  bus.o_data,  m_data);
    chk("model.perr",  bus.o_perr,  m_perr);
    chk("model.ferr",  bus.o_ferr,  m_ferr);
    chk("model.ovf",   o_ovf,       m_ovf);
    chk("model.busy",  o_busy,      m_inframe);
  endtask

  bit g_ready  = 1;
  bit g_toggle = 0;
  bit g_rand   = 0;

  task automatic put_bit(input bit s);
    bit rdy, clr;
    if (g_toggle || (g_rand && $urandom_range(0, 3) == 0)) begin
      rdy = g_rand ? ($urandom_range(0, 9) < 7) : g_ready;
      step(1'($urandom_range(0, 1)), 0, rdy, 0);
    end
    rdy = g_rand ? ($urandom_range(0, 9) < 7) : g_ready;
    clr = g_rand ? ($urandom_range(0, 19) == 0) : 1'b0;
    step(s, 1, rdy, clr);
  endtask

  task automatic send_frame(input logic [NBIT-1:0] d, input bit par, input bit stop);
    logic [NBIT-1:0] dv;
    dv = d;
    put_bit(1);
    for (int i = NBIT - 1; i >= 0; i--) put_bit(dv[i]);
    put_bit(par);
    put_bit(stop);
  endtask

  typedef struct {
    logic [NBIT-1:0] data;
    bit              par;
    bit              stop;
    logic [NBIT-1:0] exp_data;
    bit              exp_perr;
    bit              exp_ferr;
  } frame_vec_t;

  frame_vec_t vecs[5];

  initial begin
    vecs[0] = '{8'hA5, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{8'h3C, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b0};
    vecs[2] = '{8'h81, 1'b0, 1'b1, 8'h81, 1'b0, 1'b1};
    vecs[3] = '{8'h07, 1'b1, 1'b0, 8'h07, 1'b0, 1'b0};
    vecs[4] = '{8'h07, 1'b0, 1'b1, 8'h07, 1'b1, 1'b1};

    i_rst = 1'b1; i_s = 1'b0; i_bit_en = 1'b0; i_clr = 1'b0; bus.i_ready = 1'b0;
    model_reset();

    // 1. reset for 20 clocks
    repeat (20) @(posedge i_clk);
    #1;
    chk("reset.valid", bus.o_valid, 0);
    chk("reset.data",  bus.o_data,  0);
    chk("reset.perr",  bus.o_perr,  0);
    chk("reset.ferr",  bus.o_ferr,  0);
    chk("reset.ovf",   o_ovf,       0);
    chk("reset.busy",  o_busy,      0);
    i_rst = 1'b0;

    // 1/2. directed frame table, ready held, full-rate bits
    g_ready = 1;
    for (int k = 0; k < 5; k++) begin
      send_frame(vecs[k].data, vecs[k].par, vecs[k].stop);
      chk("tbl.valid", bus.o_valid, 1);
      chk("tbl.data",  bus.o_data,  vecs[k].exp_data);
      chk("tbl.perr",  bus.o_perr,  vecs[k].exp_perr);
      chk("tbl.ferr",  bus.o_ferr,  vecs[k].exp_ferr);
      repeat (3) step(0, 1, 1, 0);
      chk("tbl.idle_busy",  o_busy,      0);
      chk("tbl.idle_valid", bus.o_valid, 0);
    end

    // 3. overflow while consumer stalls, then drain and clear
    g_ready = 0;
    send_frame(8'h11, 0, 0);
    send_frame(8'h22, 0, 0);
    step(0, 1, 0, 0);
    chk("ovf.hold_data",  bus.o_data,  8'h11);
    chk("ovf.hold_valid", bus.o_valid, 1);
    chk("ovf.set",        o_ovf,       1);
    step(0, 1, 1, 0);
    chk("ovf.consumed",   bus.o_valid, 0);
    chk("ovf.sticky",     o_ovf,       1);
    step(0, 1, 0, 1);
    chk("ovf.clr",        o_ovf,       0);

    // 4. back-to-back frames, no idle bits
    g_ready = 1;
    send_frame(8'h5A, 0, 0);
    chk("b2b.first",  bus.o_data, 8'h5A);
    send_frame(8'hC3, 0, 0);
    chk("b2b.second", bus.o_data, 8'hC3);
    chk("b2b.valid",  bus.o_valid, 1);
    chk("b2b.noovf",  o_ovf, 0);
    step(0, 1, 1, 0);

    // 5. async reset mid-frame
    put_bit(1);
    for (int i = 0; i < 4; i++) put_bit(1'(i % 2));
    i_rst = 1'b1;
    #1;
    chk("arst.valid", bus.o_valid, 0);
    chk("arst.data",  bus.o_data,  0);
    chk("arst.busy",  o_busy,      0);
    chk("arst.ovf",   o_ovf,       0);
    repeat (2) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    model_reset();
    repeat (2) step(0, 1, 1, 0);
    chk("arst.nopartial", bus.o_valid, 0);
    send_frame(8'h0F, 0, 0);
    chk("arst.word", bus.o_data, 8'h0F);
    chk("arst.perr", bus.o_perr, 0);

    // 6. bit enable toggling every cycle
    g_toggle = 1;
    step(0, 1, 1, 0);
    send_frame(8'h96, 0, 0);
    chk("ten.data",  bus.o_data, 8'h96);
    chk("ten.valid", bus.o_valid, 1);
    chk("ten.perr",  bus.o_perr, 0);
    chk("ten.ferr",  bus.o_ferr, 0);
    g_toggle = 0;

    // Randomized frames against the model.
    g_rand = 1;
    for (int f = 0; f < 200; f++) begin
      int gap;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++)
        step(0, 1'($urandom_range(0, 1)), $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
      send_frame(NBIT'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 4) == 0);
    end
    repeat (4) step(0, 1, 1, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_serial_deframer
`default_nettype wire
